response_control: RTL and testbench
===================================

# response_control

- Receive side of the PSL command/response protocol: takes the PSL response interface, checks tag parity and tracks which requester (WED, read, write, restart) issued each tag.
- Routes each response to that requester as a one-cycle pulse and keeps the command credit count that gates the command arbiter.
- Sits beside command_control, which issues the commands.
- Pipeline is two registered stages with sticky error flags.

## Interface
Parameters:
- TAG_WIDTH, 8, command/response tag width; tag table depth is 2^TAG_WIDTH.
- CREDIT_WIDTH, 9, signed width of PSL response credits.
- INIT_CREDITS, 64, credit count after reset; also the upper clip bound.

Ports:
- clock  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- enabled  in  1  block active; when 0, all rsp_* and issue_* inputs are ignored and state is held.
- issue_valid  in  1  a command is issued this cycle (aligned with command_out.valid).
- issue_tag  in  TAG_WIDTH  tag of the issued command.
- issue_source  in  2  requester of the issued command: 0 WED, 1 READ, 2 WRITE, 3 RESTART.
- rsp_valid  in  1  PSL response valid.
- rsp_tag  in  TAG_WIDTH  PSL response tag.
- rsp_tag_parity  in  1  odd parity over rsp_tag.
- rsp_code  in  8  PSL response code.
- rsp_credits  in  CREDIT_WIDTH  signed credits returned with the response.
- wed_rsp_valid, read_rsp_valid, write_rsp_valid, restart_rsp_valid  out  1 each  routed response pulse.
- rsp_out_tag  out  TAG_WIDTH  tag of the routed response.
- rsp_out_code  out  8  code of the routed response.
- rsp_is_done  out  1  routed code is DONE (0x00).
- rsp_is_retry  out  1  routed code is FLUSHED (0x06) or PAGED (0x0A).
- credit_count  out  CREDIT_WIDTH  current credits, unsigned, range 0..INIT_CREDITS.
- credit_ok  out  1  credit_count > 0.
- tag_parity_error  out  1  sticky.
- tag_unknown_error  out  1  sticky.
- tag_reuse_error  out  1  sticky.
- credit_error  out  1  sticky.
- response_error  out  1  sticky.
- error_code  out  8  code of the first fatal response.

## Operation
- Stage 1 registers the rsp_* inputs.
  - rsp_valid is captured as 0 when enabled=0.
- Stage 2 runs the checks below, then registers all outputs.
- Parity check: {rsp_tag, rsp_tag_parity} must contain an odd number of ones.
  - On failure: the response is dropped, tag_parity_error is set, the table entry is untouched, and credits are still applied.
- Tag table: 2^TAG_WIDTH entries, each holding a valid bit and a 2-bit source.
  - An issue with enabled=1 writes {1, issue_source} at issue_tag.
  - Issuing to an entry that is already valid sets tag_reuse_error and overwrites the entry.
- Lookup on a parity-clean response:
  - Entry invalid: drop the response and set tag_unknown_error.
  - Entry valid: pulse the matching *_rsp_valid, drive rsp_out_tag and rsp_out_code, and clear the entry.
- Same-cycle issue and response to the same tag: the issue write wins and the entry stays valid with the new source.
- Code classes:
  - DONE sets rsp_is_done.
  - FLUSHED or PAGED sets rsp_is_retry.
  - Any other code still routes the response, sets response_error, and captures error_code if response_error was previously 0.
- Credits, computed each cycle as next = count − issue_valid + (stage-1 valid ? sign-extended rsp_credits : 0):
  - Credits are applied regardless of parity or tag result.
  - If next < 0: clip to 0 and set credit_error.
  - If next > INIT_CREDITS: clip to INIT_CREDITS and set credit_error.
  - An issue while credit_count = 0 also sets credit_error.
- All error flags clear only on reset.

## Timing
- Reset values:
  - All outputs 0, except credit_count = INIT_CREDITS and credit_ok = 1.
  - All tag table valid bits 0.
- Response latency: response on the pins in cycle N produces the routed pulse in cycle N+2, a single-cycle pulse.
  - Back-to-back responses give back-to-back pulses; throughput is 1 per cycle.
- Issue latency: an issue in cycle N is visible to lookups in stage 2 from cycle N+1.
  - A response to that tag arriving on the pins in cycle N+1 or later routes correctly.
- Credit timing:
  - Issue decrement is visible on credit_count in cycle N+1.
  - Response credits are visible in cycle N+2, the same cycle as the routed pulse.
- Error flags assert in the same cycle as the offending output would have.
- Asynchronous reset mid-pipeline discards in-flight responses; no pulse follows the reset release.
- When enabled drops: responses already in stage 1 complete, and new inputs are ignored.

## Test plan
- Reset, then issue tag 0x05 as READ, then respond to 0x05 with code 0x00, credits +1:
  - read_rsp_valid pulses 2 cycles after the response, with rsp_is_done=1.
  - credit_count goes 64→63→64.
- Issue tags 0x10 WED, 0x11 WRITE, 0x12 RESTART, then respond to them back-to-back in the order 0x12, 0x10, 0x11:
  - Pulses appear in consecutive cycles, in that order, on the correct outputs.
- Response to tag 0x20 with a bad parity bit, credits +1:
  - No pulse, tag_parity_error=1, entry 0x20 still valid.
  - A later clean response to 0x20 routes normally.
- Response to a never-issued tag 0x33:
  - tag_unknown_error=1, no pulse.
- Response code 0x07 to an issued tag, then code 0x08 to another:
  - Both responses route, response_error=1, error_code=0x07.
- Credits:
  - Issue 64 commands with no responses: credit_ok drops to 0 after the 64th.
  - A 65th issue sets credit_error, and credit_count stays 0.
  - A response with credits +70 clips credit_count to 64 and sets credit_error.

Source files
------------

// File: rtl/response_control.sv
// Receive side of the PSL command/response path: parity-checks response tags,
// routes each response to the requester that issued the tag, and tracks command credits.
module response_control #(
  parameter int TAG_WIDTH    = 8,
  parameter int CREDIT_WIDTH = 9,
  parameter int INIT_CREDITS = 64
) (
  input  logic                           clock,
  input  logic                           rstn,
  input  logic                           enabled,
  input  logic                           issue_valid,
  input  logic [TAG_WIDTH-1:0]           issue_tag,
  input  logic [1:0]                     issue_source,
  input  logic                           rsp_valid,
  input  logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic                           rsp_tag_parity,
  input  logic [7:0]                     rsp_code,
  input  logic signed [CREDIT_WIDTH-1:0] rsp_credits,
  output logic                           wed_rsp_valid,
  output logic                           read_rsp_valid,
  output logic                           write_rsp_valid,
  output logic                           restart_rsp_valid,
  output logic [TAG_WIDTH-1:0]           rsp_out_tag,
  output logic [7:0]                     rsp_out_code,
  output logic                           rsp_is_done,
  output logic                           rsp_is_retry,
  output logic [CREDIT_WIDTH-1:0]        credit_count,
  output logic                           credit_ok,
  output logic                           tag_parity_error,
  output logic                           tag_unknown_error,
  output logic                           tag_reuse_error,
  output logic                           credit_error,
  output logic                           response_error,
  output logic [7:0]                     error_code
);

  localparam int DEPTH = 1 << TAG_WIDTH;
  localparam int CW    = CREDIT_WIDTH + 2;
  localparam logic signed [CW-1:0] MAX_CREDITS = CW'(INIT_CREDITS);

  typedef enum logic [1:0] {
    SRC_WED     = 2'd0,
    SRC_READ    = 2'd1,
    SRC_WRITE   = 2'd2,
    SRC_RESTART = 2'd3
  } source_t;

  logic                           s1_valid;
  logic [TAG_WIDTH-1:0]           s1_tag;
  logic                           s1_parity;
  logic [7:0]                     s1_code;
  logic signed [CREDIT_WIDTH-1:0] s1_credits;

  logic [DEPTH-1:0] tab_valid;
  source_t          tab_src [DEPTH];

  logic                  issue_fire;
  logic                  parity_ok;
  logic                  route;
  source_t               route_src;
  logic                  code_done;
  logic                  code_retry;
  logic                  code_fatal;
  logic                  reuse_hit;
  logic signed [CW-1:0]  count_ext;
  logic signed [CW-1:0]  rsp_ext;
  logic signed [CW-1:0]  dec_ext;
  logic signed [CW-1:0]  credit_sum;
  logic                  credit_low;
  logic                  credit_high;
  logic [CREDIT_WIDTH-1:0] credit_next;
  logic                  credit_fault;

  // Stage 1: capture the raw response; new responses are ignored while disabled.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      s1_valid   <= 1'b0;
      s1_tag     <= '0;
      s1_parity  <= 1'b0;
      s1_code    <= '0;
      s1_credits <= '0;
    end else begin
      s1_valid   <= rsp_valid & enabled;
      s1_tag     <= rsp_tag;
      s1_parity  <= rsp_tag_parity;
      s1_code    <= rsp_code;
      s1_credits <= rsp_credits;
    end
  end

  assign issue_fire = issue_valid & enabled;
  assign parity_ok  = ^{s1_tag, s1_parity};
  assign route      = s1_valid & parity_ok & tab_valid[s1_tag];
  assign route_src  = tab_src[s1_tag];
  assign code_done  = (s1_code == 8'h00);
  assign code_retry = (s1_code == 8'h06) || (s1_code == 8'h0A);
  assign code_fatal = route & ~code_done & ~code_retry;
  // An entry being retired by this cycle's response is free, so reissuing it is legal.
  assign reuse_hit  = issue_fire & tab_valid[issue_tag] & ~(route & (s1_tag == issue_tag));

  assign count_ext   = signed'({2'b00, credit_count});
  assign rsp_ext     = s1_valid ? CW'(s1_credits) : '0;
  assign dec_ext     = {{(CW-1){1'b0}}, issue_fire};
  assign credit_sum  = count_ext - dec_ext + rsp_ext;
  assign credit_low  = credit_sum[CW-1];
  assign credit_high = credit_sum > MAX_CREDITS;
  assign credit_next = credit_low  ? '0 :
                       credit_high ? CREDIT_WIDTH'(INIT_CREDITS) :
                                     credit_sum[CREDIT_WIDTH-1:0];
  assign credit_fault = credit_low | credit_high | (issue_fire & (credit_count == '0));
  assign credit_ok    = |credit_count;

  // Issue write is ordered after the retire so a same-cycle reissue keeps the entry valid.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      tab_valid <= '0;
    end else begin
      if (route)      tab_valid[s1_tag]    <= 1'b0;
      if (issue_fire) tab_valid[issue_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (issue_fire) tab_src[issue_tag] <= source_t'(issue_source);
  end

  // Stage 2: register routed pulses, credits and sticky error flags.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wed_rsp_valid     <= 1'b0;
      read_rsp_valid    <= 1'b0;
      write_rsp_valid   <= 1'b0;
      restart_rsp_valid <= 1'b0;
      rsp_out_tag       <= '0;
      rsp_out_code      <= '0;
      rsp_is_done       <= 1'b0;
      rsp_is_retry      <= 1'b0;
      credit_count      <= CREDIT_WIDTH'(INIT_CREDITS);
      tag_parity_error  <= 1'b0;
      tag_unknown_error <= 1'b0;
      tag_reuse_error   <= 1'b0;
      credit_error      <= 1'b0;
      response_error    <= 1'b0;
      error_code        <= '0;
    end else begin
      wed_rsp_valid     <= route & (route_src == SRC_WED);
      read_rsp_valid    <= route & (route_src == SRC_READ);
      write_rsp_valid   <= route & (route_src == SRC_WRITE);
      restart_rsp_valid <= route & (route_src == SRC_RESTART);
      rsp_is_done       <= route & code_done;
      rsp_is_retry      <= route & code_retry;
      if (route) begin
        rsp_out_tag  <= s1_tag;
        rsp_out_code <= s1_code;
      end
      credit_count <= credit_next;
      if (s1_valid & ~parity_ok)                       tag_parity_error  <= 1'b1;
      if (s1_valid & parity_ok & ~tab_valid[s1_tag])   tag_unknown_error <= 1'b1;
      if (reuse_hit)                                   tag_reuse_error   <= 1'b1;
      if (credit_fault)                                credit_error      <= 1'b1;
      if (code_fatal) begin
        response_error <= 1'b1;
        if (!response_error) error_code <= s1_code;
      end
    end
  end

endmodule

// File: tb/tb_response_control.sv
// Directed bench for response_control; a scoreboard queue holds the routed
// responses each stimulus should produce, and a monitor retires them on output.
module tb_response_control;

  localparam int TW   = 8;
  localparam int CWD  = 9;
  localparam int INIT = 64;

  logic                  clock = 1'b0;
  logic                  rstn = 1'b0;
  logic                  enabled = 1'b0;
  logic                  issue_valid = 1'b0;
  logic [TW-1:0]         issue_tag = '0;
  logic [1:0]            issue_source = '0;
  logic                  rsp_valid = 1'b0;
  logic [TW-1:0]         rsp_tag = '0;
  logic                  rsp_tag_parity = 1'b0;
  logic [7:0]            rsp_code = '0;
  logic signed [CWD-1:0] rsp_credits = '0;
  logic                  wed_rsp_valid, read_rsp_valid, write_rsp_valid, restart_rsp_valid;
  logic [TW-1:0]         rsp_out_tag;
  logic [7:0]            rsp_out_code;
  logic                  rsp_is_done, rsp_is_retry;
  logic [CWD-1:0]        credit_count;
  logic                  credit_ok;
  logic                  tag_parity_error, tag_unknown_error, tag_reuse_error;
  logic                  credit_error, response_error;
  logic [7:0]            error_code;

  response_control #(.TAG_WIDTH(TW), .CREDIT_WIDTH(CWD), .INIT_CREDITS(INIT)) dut (
    .clock(clock), .rstn(rstn), .enabled(enabled),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_source(issue_source),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_tag_parity(rsp_tag_parity),
    .rsp_code(rsp_code), .rsp_credits(rsp_credits),
    .wed_rsp_valid(wed_rsp_valid), .read_rsp_valid(read_rsp_valid),
    .write_rsp_valid(write_rsp_valid), .restart_rsp_valid(restart_rsp_valid),
    .rsp_out_tag(rsp_out_tag), .rsp_out_code(rsp_out_code),
    .rsp_is_done(rsp_is_done), .rsp_is_retry(rsp_is_retry),
    .credit_count(credit_count), .credit_ok(credit_ok),
    .tag_parity_error(tag_parity_error), .tag_unknown_error(tag_unknown_error),
    .tag_reuse_error(tag_reuse_error), .credit_error(credit_error),
    .response_error(response_error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [1:0] src;
    logic [7:0] tag;
    logic [7:0] code;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    rsp_valid   = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  task automatic drive_issue(input logic [7:0] tag, input logic [1:0] src);
    issue_valid  = 1'b1;
    issue_tag    = tag;
    issue_source = src;
  endtask

  task automatic issue_cmd(input logic [7:0] tag, input logic [1:0] src);
    drive_issue(tag, src);
    step();
  endtask

  // Odd parity over {tag, parity}; bad=1 flips the parity bit.
  task automatic drive_rsp(input logic [7:0] tag, input logic [7:0] code, input int credits,
                           input bit bad, input bit expect_route, input logic [1:0] src);
    exp_t e;
    rsp_valid      = 1'b1;
    rsp_tag        = tag;
    rsp_tag_parity = (~^tag) ^ bad;
    rsp_code       = code;
    rsp_credits    = CWD'(credits);
    if (expect_route) begin
      e.due  = cyc + 2;
      e.src  = src;
      e.tag  = tag;
      e.code = code;
      sb.push_back(e);
    end
  endtask

  task automatic respond(input logic [7:0] tag, input logic [7:0] code, input int credits,
                         input bit bad, input bit expect_route, input logic [1:0] src);
    drive_rsp(tag, code, credits, bad, expect_route, src);
    step();
  endtask

  // Monitor: every pulse must match the oldest expected response, on its due cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [3:0] pulses;
      logic [3:0] onehot;
      exp_t       e;
      pulses = {restart_rsp_valid, write_rsp_valid, read_rsp_valid, wed_rsp_valid};
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check_output("pulse_missing_cycle", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (pulses != 4'b0000) begin
        if (sb.size() == 0) begin
          check_output("unexpected_pulse", {28'd0, pulses}, 32'd0);
        end else begin
          e = sb.pop_front();
          onehot = 4'b0001 << e.src;
          check_output("pulse_cycle", cyc, e.due);
          check_output("pulse_source", {28'd0, pulses}, {28'd0, onehot});
          check_output("rsp_out_tag", {24'd0, rsp_out_tag}, {24'd0, e.tag});
          check_output("rsp_out_code", {24'd0, rsp_out_code}, {24'd0, e.code});
          check_output("rsp_is_done", {31'd0, rsp_is_done}, {31'd0, e.code == 8'h00});
          check_output("rsp_is_retry", {31'd0, rsp_is_retry},
                       {31'd0, (e.code == 8'h06) || (e.code == 8'h0A)});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_output("reset_credit_count", credit_count, INIT);
    check_output("reset_credit_ok", credit_ok, 1);
    check_output("reset_errors", {tag_parity_error, tag_unknown_error, tag_reuse_error,
                                  credit_error, response_error}, 0);
    check_output("reset_error_code", error_code, 0);
    check_output("reset_pulses", {wed_rsp_valid, read_rsp_valid, write_rsp_valid,
                                  restart_rsp_valid}, 0);
    rstn = 1'b1;
    enabled = 1'b1;
    mon_en = 1'b1;
    step();

    // Single READ round trip
    issue_cmd(8'h05, 2'd1);
    check_output("t1_credit_after_issue", credit_count, 63);
    respond(8'h05, 8'h00, 1, 1'b0, 1'b1, 2'd1);
    check_output("t1_credit_stage1", credit_count, 63);
    step();
    check_output("t1_read_pulse", read_rsp_valid, 1);
    check_output("t1_done", rsp_is_done, 1);
    check_output("t1_credit_back", credit_count, 64);
    step();
    check_output("t1_pulse_single", read_rsp_valid, 0);

    // Out-of-order back-to-back responses to WED/WRITE/RESTART
    issue_cmd(8'h10, 2'd0);
    issue_cmd(8'h11, 2'd2);
    issue_cmd(8'h12, 2'd3);
    respond(8'h12, 8'h00, 1, 1'b0, 1'b1, 2'd3);
    respond(8'h10, 8'h06, 1, 1'b0, 1'b1, 2'd0);
    respond(8'h11, 8'h0A, 1, 1'b0, 1'b1, 2'd2);
    settle(3);
    check_output("t2_credit", credit_count, 64);

    // Bad parity drops the response but keeps the entry and applies credits
    issue_cmd(8'h20, 2'd1);
    respond(8'h20, 8'h00, 1, 1'b1, 1'b0, 2'd1);
    check_output("t3_parity_not_yet", tag_parity_error, 0);
    step();
    check_output("t3_parity_error", tag_parity_error, 1);
    check_output("t3_credit", credit_count, 64);
    settle(2);
    respond(8'h20, 8'h00, 0, 1'b0, 1'b1, 2'd1);
    settle(3);
    check_output("t3_unknown_clean", tag_unknown_error, 0);

    // Never-issued tag
    respond(8'h33, 8'h00, 0, 1'b0, 1'b0, 2'd0);
    check_output("t4_unknown_not_yet", tag_unknown_error, 0);
    step();
    check_output("t4_unknown_error", tag_unknown_error, 1);
    settle(2);

    // Fatal codes route and latch the first code
    issue_cmd(8'h40, 2'd2);
    issue_cmd(8'h41, 2'd1);
    check_output("t5_resp_err_clean", response_error, 0);
    respond(8'h40, 8'h07, 1, 1'b0, 1'b1, 2'd2);
    respond(8'h41, 8'h08, 1, 1'b0, 1'b1, 2'd1);
    step();
    check_output("t5_response_error", response_error, 1);
    check_output("t5_error_code", error_code, 8'h07);
    check_output("t5_credit", credit_count, 64);
    settle(2);

    // Tag reuse overwrites the source
    issue_cmd(8'h50, 2'd1);
    check_output("t6_reuse_clean", tag_reuse_error, 0);
    issue_cmd(8'h50, 2'd2);
    check_output("t6_reuse_error", tag_reuse_error, 1);
    respond(8'h50, 8'h00, 2, 1'b0, 1'b1, 2'd2);
    settle(3);
    check_output("t6_credit", credit_count, 64);

    // Dropping enabled: stage-1 response completes, new inputs ignored
    issue_cmd(8'h60, 2'd1);
    issue_cmd(8'h61, 2'd1);
    respond(8'h60, 8'h00, 1, 1'b0, 1'b1, 2'd1);
    enabled = 1'b0;
    drive_rsp(8'h61, 8'h00, 1, 1'b0, 1'b0, 2'd1);
    drive_issue(8'h62, 2'd0);
    settle(3);
    check_output("t7_credit_disabled", credit_count, 63);
    enabled = 1'b1;
    respond(8'h61, 8'h00, 1, 1'b0, 1'b1, 2'd1);
    settle(3);
    check_output("t7_credit", credit_count, 64);
    check_output("t7_credit_error_clean", credit_error, 0);

    // Exhaust credits
    for (int i = 0; i < 64; i++) issue_cmd(8'(8'h80 + i), 2'd1);
    check_output("t8_credit_zero", credit_count, 0);
    check_output("t8_credit_ok_low", credit_ok, 0);
    check_output("t8_credit_error_clean", credit_error, 0);
    issue_cmd(8'hC0, 2'd1);
    check_output("t8_credit_error", credit_error, 1);
    check_output("t8_credit_stays_zero", credit_count, 0);

    // Async reset with a response in flight: no pulse afterwards
    drive_rsp(8'h81, 8'h00, 1, 1'b0, 1'b0, 2'd1);
    step();
    rstn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rstn = 1'b1;
    settle(4);
    check_output("t9_credit_reset", credit_count, 64);
    check_output("t9_credit_error_reset", credit_error, 0);
    check_output("t9_flags_reset", {tag_parity_error, tag_unknown_error, tag_reuse_error,
                                    response_error}, 0);

    // Table cleared by reset, then credit overflow clip
    respond(8'h80, 8'h00, 0, 1'b0, 1'b0, 2'd1);
    step();
    check_output("t10_unknown_after_reset", tag_unknown_error, 1);
    issue_cmd(8'h07, 2'd1);
    check_output("t10_credit_issue", credit_count, 63);
    respond(8'h07, 8'h00, 70, 1'b0, 1'b1, 2'd1);
    step();
    check_output("t10_credit_clip", credit_count, 64);
    check_output("t10_credit_error", credit_error, 1);
    settle(3);

    check_output("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
